// File: rtl/lcd_init_refresh_sequencer.sv
// Powers up an HD44780-class 16x2 LCD through a single-byte write controller,
// then copies a 32-byte character buffer to the display on request.
module lcd_init_refresh_sequencer #(
  parameter int PWRUP_CYCLES = 750000,
  parameter int CMD_WAIT     = 2000,
  parameter int CLR_WAIT     = 82000
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       i_refresh,
  output logic [4:0] o_buf_addr,
  input  logic [7:0] i_buf_data,
  output logic       o_busy,
  output logic       o_init_done,
  output logic       ctrl_RS,
  output logic       ctrl_Start,
  output logic [7:0] ctrl_DATA,
  input  logic       ctrl_Done
);

  localparam int MAX_A = (PWRUP_CYCLES > CMD_WAIT) ? PWRUP_CYCLES : CMD_WAIT;
  localparam int MAX_W = (MAX_A > CLR_WAIT) ? MAX_A : CLR_WAIT;
  localparam int CW    = $clog2(MAX_W) + 1;

  localparam logic [CW-1:0] PWR_LAST = CW'(PWRUP_CYCLES - 1);
  localparam logic [CW-1:0] CMD_LAST = CW'(CMD_WAIT - 1);
  localparam logic [CW-1:0] CLR_LAST = CW'(CLR_WAIT - 1);

  localparam logic [5:0] INIT_LAST = 6'd3;
  localparam logic [5:0] LINE2_CMD = 6'd17;
  localparam logic [5:0] REF_LAST  = 6'd33;

  typedef enum logic [2:0] {
    S_PWRUP, S_ISSUE, S_WAIT_DONE, S_DELAY, S_IDLE, S_FETCH
  } state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [5:0]    idx, idx_d;
  logic          fetch_ph, fetch_ph_d;
  logic [7:0]    char_q, char_d;
  logic          pend, pend_d;
  logic          done_q;
  logic [4:0]    addr_d;
  logic          busy_d, init_done_d, rs_d, start_d;
  logic [7:0]    data_d;
  logic          done_rise;
  logic [CW-1:0] wait_last;

  function automatic logic [7:0] init_byte(input logic [1:0] i);
    unique case (i)
      2'd0:    return 8'h38;
      2'd1:    return 8'h0C;
      2'd2:    return 8'h01;
      default: return 8'h06;
    endcase
  endfunction

  assign done_rise = ctrl_Done & ~done_q;
  // ctrl_RS/ctrl_DATA still hold the byte whose completion is being timed.
  assign wait_last = (!ctrl_RS && ctrl_DATA == 8'h01) ? CLR_LAST : CMD_LAST;

  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    idx_d       = idx;
    fetch_ph_d  = fetch_ph;
    char_d      = char_q;
    pend_d      = pend | i_refresh;
    addr_d      = o_buf_addr;
    busy_d      = o_busy;
    init_done_d = o_init_done;
    rs_d        = ctrl_RS;
    data_d      = ctrl_DATA;
    start_d     = 1'b0;
    unique case (state)
      S_PWRUP: begin
        if (cnt == PWR_LAST) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = S_ISSUE;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      S_ISSUE: begin
        start_d = 1'b1;
        if (!o_init_done) begin
          rs_d   = 1'b0;
          data_d = init_byte(idx[1:0]);
        end else if (idx == '0) begin
          rs_d   = 1'b0;
          data_d = 8'h80;
        end else if (idx == LINE2_CMD) begin
          rs_d   = 1'b0;
          data_d = 8'hC0;
        end else begin
          rs_d   = 1'b1;
          data_d = char_q;
        end
        state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (done_rise) begin
          cnt_d   = '0;
          state_d = S_DELAY;
        end
      end
      S_DELAY: begin
        if (cnt == wait_last) begin
          cnt_d = '0;
          if (!o_init_done) begin
            if (idx == INIT_LAST) begin
              init_done_d = 1'b1;
              busy_d      = 1'b0;
              state_d     = S_IDLE;
            end else begin
              idx_d   = idx + 1'b1;
              state_d = S_ISSUE;
            end
          end else if (idx == REF_LAST) begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            idx_d = idx + 1'b1;
            if (idx + 1'b1 == LINE2_CMD) begin
              state_d = S_ISSUE;
            end else begin
              // Next index i maps to address i-1 on line 1, i-2 on line 2.
              addr_d     = (idx <= 6'd15) ? 5'(idx) : 5'(idx - 6'd1);
              fetch_ph_d = 1'b0;
              state_d    = S_FETCH;
            end
          end
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      S_FETCH: begin
        if (!fetch_ph) begin
          fetch_ph_d = 1'b1;
        end else begin
          char_d     = i_buf_data;
          fetch_ph_d = 1'b0;
          state_d    = S_ISSUE;
        end
      end
      S_IDLE: begin
        if (pend) begin
          pend_d  = i_refresh;
          busy_d  = 1'b1;
          idx_d   = '0;
          addr_d  = '0;
          state_d = S_ISSUE;
        end
      end
      default: state_d = S_PWRUP;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state       <= S_PWRUP;
      cnt         <= '0;
      idx         <= '0;
      fetch_ph    <= 1'b0;
      char_q      <= '0;
      pend        <= 1'b1;
      done_q      <= 1'b0;
      o_buf_addr  <= '0;
      o_busy      <= 1'b1;
      o_init_done <= 1'b0;
      ctrl_RS     <= 1'b0;
      ctrl_Start  <= 1'b0;
      ctrl_DATA   <= '0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      idx         <= idx_d;
      fetch_ph    <= fetch_ph_d;
      char_q      <= char_d;
      pend        <= pend_d;
      done_q      <= ctrl_Done;
      o_buf_addr  <= addr_d;
      o_busy      <= busy_d;
      o_init_done <= init_done_d;
      ctrl_RS     <= rs_d;
      ctrl_Start  <= start_d;
      ctrl_DATA   <= data_d;
    end
  end

endmodule

// File: tb/tb_lcd_init_refresh_sequencer.sv
// Bench for lcd_init_refresh_sequencer: byte-controller and buffer-RAM models,
// expected byte streams built from the display protocol and buffer contents.
`timescale 1ns/1ps
module tb_lcd_init_refresh_sequencer;
  localparam int PWR  = 20;
  localparam int CMDW = 5;
  localparam int CLRW = 12;
  localparam int LAT  = 6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       refresh = 1'b0;
  logic       hold = 1'b0;
  logic       busy, init_done, rs, start, done, mdone;
  logic [4:0] addr;
  logic [7:0] buf_data, data;
  logic [7:0] mem [32];
  int         cyc = 0;
  int         mcnt;
  logic       start_prev = 1'b0;

  typedef struct { logic rs; logic [7:0] data; int cyc; bit overlap; bit wide; } rec_t;
  typedef struct { logic rs; logic [7:0] data; } byte_t;
  typedef struct { int idle_p; int mid_p; int nref; bit use_hello; } vec_t;

  rec_t  got[$];
  byte_t exp_q[$];
  vec_t  vecs[6];
  int    checks = 0, errors = 0;
  int    base, rel, n;

  always #5 clk = ~clk;

  lcd_init_refresh_sequencer #(.PWRUP_CYCLES(PWR), .CMD_WAIT(CMDW), .CLR_WAIT(CLRW)) dut (
    .iCLK(clk), .iRST_N(rst_n), .i_refresh(refresh), .o_buf_addr(addr),
    .i_buf_data(buf_data), .o_busy(busy), .o_init_done(init_done), .ctrl_RS(rs),
    .ctrl_Start(start), .ctrl_DATA(data), .ctrl_Done(done));

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    buf_data <= mem[addr];
  end

  // Byte controller: Done drops on Start and rises LAT cycles later; hold pins it high.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mdone <= 1'b0;
      mcnt  <= 0;
    end else if (start) begin
      mdone <= 1'b0;
      mcnt  <= LAT;
    end else if (mcnt != 0 && !hold) begin
      mcnt <= mcnt - 1;
      if (mcnt == 1) mdone <= 1'b1;
    end
  assign done = hold | mdone;

  always @(negedge clk) begin
    if (rst_n && start) got.push_back('{rs, data, cyc, (mcnt != 0), start_prev});
    start_prev <= rst_n && start;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, " start"}, start, 0);
    check({tag, " rs"}, rs, 0);
    check({tag, " data"}, data, 0);
    check({tag, " addr"}, addr, 0);
    check({tag, " busy"}, busy, 1);
    check({tag, " init_done"}, init_done, 0);
  endtask

  function automatic void push(logic r, logic [7:0] d);
    byte_t b;
    b.rs = r;
    b.data = d;
    exp_q.push_back(b);
  endfunction

  function automatic void model_init();
    push(1'b0, 8'h38); push(1'b0, 8'h0C); push(1'b0, 8'h01); push(1'b0, 8'h06);
  endfunction

  function automatic void model_refresh();
    push(1'b0, 8'h80);
    for (int i = 0; i < 16; i++) push(1'b1, mem[i]);
    push(1'b0, 8'hC0);
    for (int i = 16; i < 32; i++) push(1'b1, mem[i]);
  endfunction

  task automatic fill_hello();
    string s1, s2;
    s1 = "HELLO, LCD WORLD";
    s2 = "0123456789abcdef";
    for (int i = 0; i < 16; i++) begin
      mem[i]      = s1[i];
      mem[i + 16] = s2[i];
    end
  endtask

  task automatic pulse();
    refresh = 1'b1;
    tick();
    refresh = 1'b0;
  endtask

  task automatic wait_starts(input int target, input string tag);
    int k = 0;
    while (got.size() < target && k < 4000) begin tick(); k++; end
    if (got.size() < target) begin
      checks++; errors++;
      $display("FAIL %s timeout: %0d starts, required %0d", tag, got.size(), target);
    end
  endtask

  task automatic wait_idle(input string tag);
    int k = 0, low = 0;
    while (low < 8 && k < 4000) begin
      tick(); k++;
      low = busy ? 0 : low + 1;
    end
    if (low < 8) begin
      checks++; errors++;
      $display("FAIL %s idle timeout: busy=%0d, required 0", tag, busy);
    end
  endtask

  task automatic compare_stream(input int b, input string tag);
    int e0 = errors;
    check({tag, " start count"}, got.size() - b, exp_q.size());
    for (int i = 0; i < exp_q.size() && b + i < got.size() && errors - e0 < 4; i++) begin
      check($sformatf("%s byte%0d rs", tag, i), got[b + i].rs, exp_q[i].rs);
      check($sformatf("%s byte%0d data", tag, i), got[b + i].data, exp_q[i].data);
      check($sformatf("%s byte%0d overlap", tag, i), got[b + i].overlap, 0);
      check($sformatf("%s byte%0d pulse width", tag, i), got[b + i].wide, 0);
    end
  endtask

  task automatic check_init_timing(input int b, input string tag);
    int g1, g2, g3, w;
    if (got.size() < b + 38) return;
    check({tag, " pwrup quiet"}, (got[b].cyc - rel > PWR && got[b].cyc - rel <= PWR + 2) ? 1 : 0, 1);
    g1 = got[b + 1].cyc - got[b].cyc;
    g2 = got[b + 2].cyc - got[b + 1].cyc;
    g3 = got[b + 3].cyc - got[b + 2].cyc;
    check({tag, " cmd gaps equal"}, g2, g1);
    check({tag, " clear gap extra"}, g3 - g2, CLRW - CMDW);
    for (int i = 1; i < 38; i++) begin
      w = (!got[b + i - 1].rs && got[b + i - 1].data == 8'h01) ? CLRW : CMDW;
      check($sformatf("%s gap%0d above done+wait", tag, i),
            (got[b + i].cyc - got[b + i - 1].cyc > LAT + w) ? 1 : 0, 1);
    end
  endtask

  initial begin
    vecs[0] = '{idle_p: 1, mid_p: 0, nref: 1, use_hello: 1'b1};
    vecs[1] = '{idle_p: 3, mid_p: 0, nref: 2, use_hello: 1'b0};
    vecs[2] = '{idle_p: 1, mid_p: 3, nref: 2, use_hello: 1'b0};
    vecs[3] = '{idle_p: 0, mid_p: 0, nref: 0, use_hello: 1'b0};
    vecs[4] = '{idle_p: 2, mid_p: 2, nref: 2, use_hello: 1'b0};
    vecs[5] = '{idle_p: 1, mid_p: 1, nref: 2, use_hello: 1'b0};

    fill_hello();
    repeat (3) @(posedge clk);
    #2;
    check_reset("reset");
    @(negedge clk);
    rst_n = 1'b1;
    rel = cyc;
    base = got.size();
    exp_q.delete();
    model_init();
    model_refresh();
    wait_starts(base + 38, "init");
    wait_idle("init");
    compare_stream(base, "init");
    check_init_timing(base, "init");
    check("init done flag", init_done, 1);
    check("init busy", busy, 0);

    for (int v = 0; v < 6; v++) begin
      if (vecs[v].use_hello) fill_hello();
      else for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
      base = got.size();
      exp_q.delete();
      repeat (vecs[v].nref) model_refresh();
      for (int p = 0; p < vecs[v].idle_p; p++) begin
        pulse();
        repeat ($urandom_range(0, 3)) tick();
      end
      if (vecs[v].mid_p > 0) begin
        wait_starts(base + $urandom_range(2, 28), $sformatf("vec%0d mid", v));
        for (int p = 0; p < vecs[v].mid_p; p++) begin
          pulse();
          repeat ($urandom_range(1, 3)) tick();
        end
      end
      wait_idle($sformatf("vec%0d", v));
      compare_stream(base, $sformatf("vec%0d", v));
      if (vecs[v].nref > 0) check($sformatf("vec%0d final addr", v), addr, 31);
      check($sformatf("vec%0d busy", v), busy, 0);
      check($sformatf("vec%0d init_done", v), init_done, 1);
    end

    // Stale Done: line already high when the next byte issues.
    for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
    base = got.size();
    exp_q.delete();
    model_refresh();
    pulse();
    wait_starts(base + 3, "stale pre");
    repeat (2) tick();
    n = 0;
    while (!done && n < 100) begin tick(); n++; end
    hold = 1'b1;
    wait_starts(base + 4, "stale issue");
    n = got.size();
    repeat (40) tick();
    check("stale level no advance", got.size(), n);
    hold = 1'b0;
    wait_idle("stale");
    compare_stream(base, "stale");

    // Reset in the middle of a refresh, then a request during the replayed init.
    base = got.size();
    pulse();
    wait_starts(base + 10, "midreset pre");
    repeat (2) tick();
    #3;
    rst_n = 1'b0;
    #1;
    check_reset("mid reset");
    repeat (2) tick();
    @(negedge clk);
    rst_n = 1'b1;
    rel = cyc;
    base = got.size();
    exp_q.delete();
    model_init();
    model_refresh();
    repeat (30) tick();
    pulse();
    wait_starts(base + 38, "replay");
    wait_idle("replay");
    compare_stream(base, "replay");
    check_init_timing(base, "replay");
    check("replay init_done", init_done, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
